// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback over a shared datapath.
// Optional bne support is enabled by defining the macro MC_BNE_EN.
module mips_multicycle_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNTW          = 16,
  parameter int ALUCW         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [ALUCW-1:0] alucontrol,
  output logic             illegal_op,
  output logic [CNTW-1:0]  instr_count
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;
  localparam logic [3:0] BNE      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  logic [3:0]      state_r;
  logic [3:0]      next_s;
  logic [CNTW-1:0] instr_count_r;
  logic            mr_s;
  logic            illegal_s;
  logic            retire_s;
  logic            pcwrite_s;
  logic            branch_s;
  logic            bne_s;
  logic [1:0]      aluop_s;
  logic [2:0]      aluctl_s;

  assign mr_s        = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign instr_count = instr_count_r;
  assign pcen        = pcwrite_s | (branch_s & zero) | (bne_s & ~zero);
  assign illegal_op  = illegal_s;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= FETCH;
      instr_count_r <= '0;
    end else begin
      state_r <= next_s;
      if (retire_s) instr_count_r <= instr_count_r + CNTW'(1);
      else          instr_count_r <= instr_count_r;
    end
  end

  // Next-state logic; unsupported opcodes are flagged while in DECODE
  always_comb begin
    next_s    = FETCH;
    illegal_s = 1'b0;
    case (state_r)
      FETCH:    next_s = mr_s ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = MEMADR;
          OP_RTYPE:     next_s = EXECUTE;
          OP_BEQ:       next_s = BRANCH;
          OP_ADDI:      next_s = ADDIEXEC;
          OP_J:         next_s = JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       next_s = BNE;
`endif
          default: begin
            next_s    = FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      MEMADR:   next_s = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    next_s = mr_s ? MEMWB : MEMRD;
      MEMWR:    next_s = mr_s ? FETCH : MEMWR;
      EXECUTE:  next_s = ALUWB;
      ADDIEXEC: next_s = ADDIWB;
      default:  next_s = FETCH;
    endcase
  end

  // Retirement happens on the edge leaving each instruction's final state
  always_comb begin
    case (state_r)
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire_s = 1'b1;
      MEMWR:   retire_s = mr_s;
`ifdef MC_BNE_EN
      BNE:     retire_s = 1'b1;
`endif
      default: retire_s = 1'b0;
    endcase
  end

  // Moore outputs per state; anything not driven in a state stays 0
  always_comb begin
    pcwrite_s = 1'b0;
    branch_s  = 1'b0;
    bne_s     = 1'b0;
    aluop_s   = 2'b00;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    case (state_r)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = mr_s;
        pcwrite_s = mr_s;
      end
      DECODE:   alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:    iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop_s = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop_s  = 2'b01;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
      end
`ifdef MC_BNE_EN
      BNE: begin
        alusrca = 1'b1;
        aluop_s = 2'b01;
        pcsrc   = 2'b01;
        bne_s   = 1'b1;
      end
`endif
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:   regwrite = 1'b1;
      JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
      default:  pcwrite_s = 1'b0;
    endcase
  end

  // ALU control from aluop and funct, zero-extended to ALUCW
  always_comb begin
    case (aluop_s)
      2'b00: aluctl_s = 3'b010;
      2'b01: aluctl_s = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: aluctl_s = 3'b010;
          6'b100010: aluctl_s = 3'b110;
          6'b100100: aluctl_s = 3'b000;
          6'b100101: aluctl_s = 3'b001;
          6'b101010: aluctl_s = 3'b111;
          default:   aluctl_s = 3'b000;
        endcase
      end
      default: aluctl_s = 3'b000;
    endcase
    alucontrol      = '0;
    alucontrol[2:0] = aluctl_s;
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench: each instruction is modelled as a string of phase letters derived
// from its opcode; expected outputs per phase come from the control table.
module tb_mips_multicycle_controller;
  localparam int TB_CNTW = 4;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [TB_CNTW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  string seq;
  int idx;
  int exp_count;
  bit done;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.MEM_HANDSHAKE(1), .CNTW(TB_CNTW), .ALUCW(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  // F fetch, D decode, A address, R read, W load writeback, S store, E execute,
  // X R-type writeback, B beq, N bne, I addi execute, J addi writeback, P jump
  function automatic string phases(input logic [5:0] o);
    case (o)
      6'b100011: return "FDARW";
      6'b101011: return "FDAS";
      6'b000000: return "FDEX";
      6'b000100: return "FDB";
      6'b001000: return "FDIJ";
      6'b000010: return "FDP";
`ifdef MC_BNE_EN
      6'b000101: return "FDN";
`endif
      default:   return "FD";
    endcase
  endfunction

  function automatic logic [2:0] fdec(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] expect_out(input byte p, input bit mr, input bit z,
                                             input logic [5:0] f, input bit ill);
    logic e_pcen, e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_ill;
    logic [1:0] e_sb, e_ps;
    logic [2:0] e_ac;
    {e_pcen, e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_ill} = 9'b0;
    e_sb = 2'b00; e_ps = 2'b00; e_ac = 3'b010;
    case (p)
      "F": begin e_sb = 2'b01; e_ir = mr; e_pcen = mr; end
      "D": begin e_sb = 2'b11; e_ill = ill; end
      "A": begin e_sa = 1'b1; e_sb = 2'b10; end
      "R": e_iord = 1'b1;
      "W": begin e_m2r = 1'b1; e_rw = 1'b1; end
      "S": begin e_iord = 1'b1; e_mw = 1'b1; end
      "E": begin e_sa = 1'b1; e_ac = fdec(f); end
      "X": begin e_rd = 1'b1; e_rw = 1'b1; end
      "B": begin e_sa = 1'b1; e_ac = 3'b110; e_ps = 2'b01; e_pcen = z; end
      "N": begin e_sa = 1'b1; e_ac = 3'b110; e_ps = 2'b01; e_pcen = ~z; end
      "I": begin e_sa = 1'b1; e_sb = 2'b10; end
      "J": e_rw = 1'b1;
      "P": begin e_ps = 2'b10; e_pcen = 1'b1; end
      default: e_ac = 3'b010;
    endcase
    return {e_pcen, e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_sb, e_ps, e_ac, e_ill};
  endfunction

  task automatic check(input string tag, input byte p, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s phase %c: observed %0h expected %0h", tag, p, obs, exp);
    end
  endtask

  task automatic start_instr(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    seq = phases(o);
    idx = 0;
    done = 1'b0;
  endtask

  // One clock: drive inputs, check mid-cycle, then advance the model after the edge
  task automatic do_cycle(input bit mr, input bit z, input bit rst, input bit chk);
    byte p;
    bit memph;
    mem_ready = mr;
    zero = z;
    reset = rst;
    p = seq[idx];
    @(negedge clk);
    if (chk) begin
      check("outputs", p,
            {16'b0, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, alucontrol, illegal_op},
            {16'b0, expect_out(p, mr, z, funct, seq == "FD")});
      check("instr_count", p, {28'b0, instr_count}, exp_count % (1 << TB_CNTW));
    end
    @(posedge clk);
    #1;
    memph = (p == "F") || (p == "R") || (p == "S");
    if (rst) begin
      exp_count = 0;
      idx = 0;
      done = 1'b1;
    end else if (!(memph && !mr)) begin
      idx++;
      if (idx == seq.len()) begin
        if (seq != "FD") exp_count++;
        idx = 0;
        done = 1'b1;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                           input byte stall_ph, input int nstall, input bit rnd);
    int n;
    int left;
    bit mr;
    bit zz;
    start_instr(o, f);
    n = 0;
    left = nstall;
    while (!done && n < 60) begin
      if (rnd) begin
        mr = ($urandom_range(0, 3) != 0);
        zz = $urandom_range(0, 1) == 1;
      end else begin
        mr = !((seq[idx] == stall_ph) && (left > 0));
        if (!mr) left--;
        zz = z;
      end
      do_cycle(mr, zz, 1'b0, 1'b1);
      n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL timeout: observed %0d cycles without completion, expected completion", n);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [0:8];
    logic [5:0] fns [0:5];
    logic [5:0] ro, rf;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
            6'b000010, 6'b000101, 6'b111111, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    exp_count = 0;
    start_instr(6'b100011, 6'b0);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0);

    run_instr(6'b100011, 6'b000000, 1'b0, "R", 2, 1'b0);
    run_instr(6'b000000, 6'b100010, 1'b0, "-", 0, 1'b0);
    run_instr(6'b000100, 6'b000000, 1'b1, "-", 0, 1'b0);
    run_instr(6'b000100, 6'b000000, 1'b0, "-", 0, 1'b0);
    run_instr(6'b111111, 6'b000000, 1'b0, "-", 0, 1'b0);

    // store stalled in MEMWR, then reset lands mid-instruction
    start_instr(6'b101011, 6'b000000);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1);

    run_instr(6'b101011, 6'b000000, 1'b0, "S", 1, 1'b0);
    run_instr(6'b001000, 6'b000000, 1'b0, "-", 0, 1'b0);
    run_instr(6'b000010, 6'b000000, 1'b0, "-", 0, 1'b0);
    run_instr(6'b000101, 6'b000000, 1'b1, "-", 0, 1'b0);
    run_instr(6'b000101, 6'b000000, 1'b0, "-", 0, 1'b0);
    run_instr(6'b000000, 6'b101010, 1'b0, "F", 3, 1'b0);

    for (int k = 0; k < 250; k++) begin
      ro = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) ro = 6'($urandom_range(0, 63));
      rf = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) rf = 6'($urandom_range(0, 63));
      run_instr(ro, rf, 1'b0, "-", 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Multicycle successor to the single-cycle MIPS controller. A Moore FSM sequences one instruction over 3-5 cycles through a shared memory/ALU datapath. It adds an optional memory-ready handshake, an illegal-opcode flag and a retired-instruction counter. It sits between the instruction register (op, funct) and the multicycle datapath, and reuses the existing 2-bit aluop and 3-bit alucontrol encodings.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored (treated as 1)
CNTW, 16, width of retired-instruction counter
ALUCW, 3, alucontrol width; bits above [2:0] driven 0

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
op  input  6  instr[31:26], sampled from instruction register
funct  input  6  instr[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes access this cycle
pcen  output  1  PC write enable = pcwrite | (branch & zero)
iord  output  1  0 = PC address, 1 = ALUOut address
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  1 = rd, 0 = rt
memtoreg  output  1  1 = Data register, 0 = ALUOut
regwrite  output  1  register-file write
alusrca  output  1  0 = PC, 1 = A
alusrcb  output  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
pcsrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target
alucontrol  output  ALUCW  from aluop/funct: 00 -> 010; 01 -> 110; 10 -> funct decode (ADD 010, SUB 110, AND 000, OR 001, SLT 111, other 000)
illegal_op  output  1  one-cycle pulse in DECODE for unsupported op
instr_count  output  CNTW  retired instructions, wraps at 2^CNTW

Behaviour:
- State register 4 bits. All outputs are combinational from state, except pcen (uses zero) and the mem_ready gating. All outputs not listed for a state are 0.
- reset high at an edge: state <= FETCH, instr_count <= 0. This applies mid-instruction; no write strobe may be issued in the cycle after reset. Outputs then equal FETCH values.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcwrite=mem_ready. On mem_ready -> DECODE, else stay.
- DECODE: alusrca=0, alusrcb=11, aluop=00.
  - Next state by op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP.
  - Any other op -> FETCH, with illegal_op=1 for this cycle; not counted as retired.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. On mem_ready -> MEMWB, else stay.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state -> FETCH.
- MEMWR: iord=1, memwrite=1. memwrite is held while waiting. On mem_ready -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next state -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next state -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next state -> FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. Next state -> ADDIWB.
- ADDIWB: regdst=0, regwrite=1. Next state -> FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state -> FETCH.
- Unused state encodings -> FETCH next cycle, all outputs 0.
- Cycle counts with mem_ready constantly 1:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
- instr_count increments by 1 on the edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP. It wraps from 2^CNTW-1 to 0.
- With MEM_HANDSHAKE=0, mem_ready is ignored and no wait cycles occur.

Optional Feature:
Macro MC_BNE_EN.
- Defined: op 000101 (bne) is decoded in DECODE -> BNE state. BNE drives the same outputs as BRANCH, but pcen = pcwrite | (branch & ~zero). It retires like beq.
- Undefined: 000101 is illegal: illegal_op pulses and the FSM returns to FETCH.

Test Plan:
- Reset for 2 cycles then release, mem_ready=1 -> first cycle in FETCH with irwrite=1, pcen=1, alusrcb=01, instr_count=0.
- lw (op 100011), mem_ready low for 2 cycles in MEMRD -> iord=1 held 3 cycles; regwrite=1 and memtoreg=1 for exactly one cycle; instr_count 0 -> 1; 7 cycles total.
- R-type SUB (funct 100010) -> alucontrol=110 in EXECUTE; regdst=1, regwrite=1 in ALUWB; 4 cycles.
- beq with zero=1, then zero=0 -> pcen=1 and pcsrc=01 in BRANCH for the first; pcen=0 for the second; both counted.
- op 111111 -> illegal_op pulses one cycle in DECODE; FETCH next; instr_count unchanged; no regwrite or memwrite.
- Assert reset during MEMWR with mem_ready=0 -> memwrite=0 the next cycle, FSM in FETCH, instr_count=0.
